// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Registers the winner's operands, captures the ALU outputs one cycle later and holds the response.
module alu_share_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*WIDTH-1:0] req_operandA,
   input  logic [2*WIDTH-1:0] req_operandB,
   input  logic [5:0]         req_command,
   output logic [1:0]         rsp_valid,
   input  logic [1:0]         rsp_ready,
   output logic [WIDTH-1:0]   rsp_result,
   output logic               rsp_carryout,
   output logic               rsp_zero,
   output logic               rsp_overflow,
   output logic [WIDTH-1:0]   alu_operandA,
   output logic [WIDTH-1:0]   alu_operandB,
   output logic [2:0]         alu_command,
   input  logic [WIDTH-1:0]   alu_result,
   input  logic               alu_carryout,
   input  logic               alu_zero,
   input  logic               alu_overflow,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state_q;
   logic   grant_q;
   logic   last_grant_q;
   logic   winner;

   // Ties go to the requester not served last; a lone requester always wins.
   always_comb begin
      winner    = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
      req_ready = 2'b00;
      if (reset_n && (state_q == IDLE) && req_valid[winner]) begin
         req_ready[winner] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         alu_operandA <= '0;
         alu_operandB <= '0;
         alu_command  <= '0;
         rsp_result   <= '0;
         rsp_carryout <= 1'b0;
         rsp_zero     <= 1'b0;
         rsp_overflow <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req_ready) begin
                  state_q      <= EXEC;
                  grant_q      <= winner;
                  alu_operandA <= winner ? req_operandA[2*WIDTH-1:WIDTH] : req_operandA[WIDTH-1:0];
                  alu_operandB <= winner ? req_operandB[2*WIDTH-1:WIDTH] : req_operandB[WIDTH-1:0];
                  alu_command  <= winner ? req_command[5:3] : req_command[2:0];
               end
            end
            EXEC: begin
               state_q      <= RESP;
               rsp_result   <= alu_result;
               rsp_carryout <= alu_carryout;
               rsp_zero     <= alu_zero;
               rsp_overflow <= alu_overflow;
            end
            RESP: begin
               if (rsp_ready[grant_q]) begin
                  state_q      <= IDLE;
                  last_grant_q <= grant_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign rsp_valid = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized self-checking bench for alu_share_arbiter with a behavioural ALU and arbitration model.
module tb_alu_share_arbiter;

   typedef struct packed {
      logic [31:0] r;
      logic        c;
      logic        z;
      logic        v;
   } alu_out_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_operandA;
   logic [63:0] req_operandB;
   logic [5:0]  req_command;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_carryout, rsp_zero, rsp_overflow;
   logic [31:0] alu_operandA, alu_operandB;
   logic [2:0]  alu_command;
   logic [31:0] alu_result;
   logic        alu_carryout, alu_zero, alu_overflow;
   logic        busy;

   int       n_pass = 0;
   int       n_total = 0;
   logic     m_last;
   logic     obs_g;
   logic [31:0] m_a, m_b;
   logic [2:0]  m_c;
   bit       alu_ovr = 1'b0;
   alu_out_t ovr_val = '0;
   alu_out_t alu_o;

   alu_share_arbiter #(.WIDTH(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_operandA(req_operandA), .req_operandB(req_operandB), .req_command(req_command),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_carryout(rsp_carryout), .rsp_zero(rsp_zero),
      .rsp_overflow(rsp_overflow),
      .alu_operandA(alu_operandA), .alu_operandB(alu_operandB), .alu_command(alu_command),
      .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_zero(alu_zero),
      .alu_overflow(alu_overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural 32-bit ALU: 0 add, 1 sub, 2 xor, 3 slt, 4 and, 5 nand, 6 nor, 7 or.
   function automatic alu_out_t alu_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      alu_out_t    o;
      logic [32:0] s;
      o = '0;
      case (c)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            o.r = s[31:0]; o.c = s[32];
            o.v = (a[31] == b[31]) && (s[31] != a[31]);
         end
         3'd1: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            o.r = s[31:0]; o.c = s[32];
            o.v = (a[31] != b[31]) && (s[31] != a[31]);
         end
         3'd2: o.r = a ^ b;
         3'd3: o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd4: o.r = a & b;
         3'd5: o.r = ~(a & b);
         3'd6: o.r = ~(a | b);
         default: o.r = a | b;
      endcase
      o.z = (o.r == 32'd0);
      return o;
   endfunction

   always_comb begin
      alu_o = alu_fn(alu_command, alu_operandA, alu_operandB);
      if (alu_ovr) alu_o = ovr_val;
   end
   assign {alu_result, alu_carryout, alu_zero, alu_overflow} = alu_o;

   task automatic apply_reset();
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      reset_n   = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      m_last  = 1'b1;
   endtask

   // One full operation from IDLE back to IDLE, checked against the model at every cycle.
   task automatic op_cycle(input logic [1:0] vm, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [2:0] c0, input logic [31:0] a1, input logic [31:0] b1,
                           input logic [2:0] c1, input bit keep);
      logic        g;
      logic [1:0]  er;
      logic [31:0] ea, eb;
      logic [2:0]  ec;
      alu_out_t    eo;
      g  = (vm == 2'b11) ? ~m_last : vm[1];
      er = g ? 2'b10 : 2'b01;
      ea = g ? a1 : a0;
      eb = g ? b1 : b0;
      ec = g ? c1 : c0;
      eo = alu_fn(ec, ea, eb);
      req_valid    = vm;
      req_operandA = {a1, a0};
      req_operandB = {b1, b0};
      req_command  = {c1, c0};
      rsp_ready    = 2'b00;
      #1;
      n_total++;
      if ({busy, req_ready} !== {1'b0, er})
         $display("FAIL accept: busy/req_ready got %b%b expected 0%b", busy, req_ready, er);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({busy, req_ready, rsp_valid, alu_operandA, alu_operandB, alu_command} !== {1'b1, 2'b00, 2'b00, ea, eb, ec})
         $display("FAIL exec: got busy=%b rdy=%b vld=%b A=%h B=%h cmd=%h expected A=%h B=%h cmd=%h",
                  busy, req_ready, rsp_valid, alu_operandA, alu_operandB, alu_command, ea, eb, ec);
      else n_pass++;
      if (!keep) req_valid = 2'b00;
      @(negedge clk);
      obs_g = rsp_valid[1];
      n_total++;
      if ({rsp_valid, req_ready, busy} !== {er, 2'b00, 1'b1})
         $display("FAIL resp_valid: got vld=%b rdy=%b busy=%b expected vld=%b", rsp_valid, req_ready, busy, er);
      else n_pass++;
      n_total++;
      if ({rsp_result, rsp_carryout, rsp_zero, rsp_overflow} !== eo)
         $display("FAIL resp_data: got %h expected %h", {rsp_result, rsp_carryout, rsp_zero, rsp_overflow}, eo);
      else n_pass++;
      rsp_ready = er;
      @(negedge clk);
      n_total++;
      if ({busy, rsp_valid} !== 3'b000)
         $display("FAIL return_idle: busy/rsp_valid got %b%b expected 000", busy, rsp_valid);
      else n_pass++;
      rsp_ready = 2'b00;
      m_last = g;
      m_a = ea; m_b = eb; m_c = ec;
   endtask

   task automatic test_reset();
      req_valid = 2'b11; rsp_ready = 2'b11;
      req_operandA = '1; req_operandB = '1; req_command = '1;
      reset_n = 1'b0;
      #1;
      n_total++;
      if ({rsp_valid, req_ready, busy, alu_operandA, alu_operandB, alu_command,
           rsp_result, rsp_carryout, rsp_zero, rsp_overflow} !== '0)
         $display("FAIL reset_outputs: vld=%b rdy=%b busy=%b A=%h B=%h cmd=%h res=%h", rsp_valid,
                  req_ready, busy, alu_operandA, alu_operandB, alu_command, rsp_result);
      else n_pass++;
      apply_reset();
   endtask

   task automatic test_single();
      op_cycle(2'b01, 32'h5, 32'h3, 3'd0, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0);
      n_total++;
      if ({rsp_result, rsp_zero} !== {32'h8, 1'b0})
         $display("FAIL single_add: result/zero got %h/%b expected 00000008/0", rsp_result, rsp_zero);
      else n_pass++;
   endtask

   task automatic test_tie();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         op_cycle(2'b11, $urandom, $urandom, 3'($urandom_range(0, 7)),
                  $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b1);
         n_total++;
         if (obs_g !== 1'(i % 2))
            $display("FAIL tie_grant: op %0d granted %b expected %b", i, obs_g, 1'(i % 2));
         else n_pass++;
      end
      req_valid = 2'b00;
   endtask

   task automatic test_flags();
      op_cycle(2'b10, $urandom, $urandom, 3'd1, 32'h7FFFFFFF, 32'h1, 3'd0, 1'b0);
      n_total++;
      if ({rsp_result, rsp_carryout, rsp_zero, rsp_overflow} !== {32'h80000000, 1'b0, 1'b0, 1'b1})
         $display("FAIL flags: got %h c=%b z=%b v=%b expected 80000000 c=0 z=0 v=1",
                  rsp_result, rsp_carryout, rsp_zero, rsp_overflow);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic        g;
      logic [1:0]  er;
      logic [31:0] a, b;
      logic [2:0]  c;
      alu_out_t    eo;
      g = 1'($urandom_range(0, 1));
      er = g ? 2'b10 : 2'b01;
      a = $urandom; b = $urandom; c = 3'($urandom_range(0, 7));
      eo = alu_fn(c, a, b);
      req_valid = er;
      req_operandA = {a, a}; req_operandB = {b, b}; req_command = {c, c};
      rsp_ready = 2'b00;
      @(negedge clk);
      req_valid = 2'b11;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         alu_ovr = 1'b1;
         ovr_val = {$urandom, 3'($urandom_range(0, 7))};
         rsp_ready = (i % 2 == 1) ? ~er : 2'b00;
         @(negedge clk);
         n_total++;
         if ({rsp_valid, busy, req_ready, rsp_result, rsp_carryout, rsp_zero, rsp_overflow} !== {er, 1'b1, 2'b00, eo})
            $display("FAIL backpressure: cycle %0d vld=%b busy=%b rdy=%b data=%h expected vld=%b data=%h", i,
                     rsp_valid, busy, req_ready, {rsp_result, rsp_carryout, rsp_zero, rsp_overflow}, er, eo);
         else n_pass++;
      end
      alu_ovr = 1'b0;
      req_valid = 2'b00;
      rsp_ready = er;
      @(negedge clk);
      n_total++;
      if ({busy, rsp_valid} !== 3'b000)
         $display("FAIL backpressure_release: busy/vld got %b%b expected 000", busy, rsp_valid);
      else n_pass++;
      rsp_ready = 2'b00;
      m_last = g;
   endtask

   task automatic test_reset_mid_exec();
      op_cycle(2'b01, $urandom, $urandom, 3'd0, $urandom, $urandom, 3'd0, 1'b0);
      req_valid = 2'b10;
      req_operandA = {$urandom, $urandom}; req_operandB = {$urandom, $urandom};
      req_command = 6'($urandom);
      rsp_ready = 2'b11;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_total++;
      if ({rsp_valid, req_ready, busy, alu_operandA, alu_operandB, alu_command,
           rsp_result, rsp_carryout, rsp_zero, rsp_overflow} !== '0)
         $display("FAIL reset_mid_exec: vld=%b rdy=%b busy=%b A=%h B=%h cmd=%h res=%h expected all 0",
                  rsp_valid, req_ready, busy, alu_operandA, alu_operandB, alu_command, rsp_result);
      else n_pass++;
      repeat (2) begin
         @(negedge clk);
         n_total++;
         if ({rsp_valid, busy} !== 3'b000)
            $display("FAIL reset_hold: vld/busy got %b%b expected 000", rsp_valid, busy);
         else n_pass++;
      end
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      reset_n = 1'b1;
      m_last = 1'b1;
      op_cycle(2'b11, $urandom, $urandom, 3'($urandom_range(0, 7)),
               $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0);
      n_total++;
      if (obs_g !== 1'b0)
         $display("FAIL reset_tie: granted %b expected 0", obs_g);
      else n_pass++;
   endtask

   task automatic test_idle_hold();
      req_valid = 2'b00;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_total++;
         if ({busy, req_ready, alu_operandA, alu_operandB, alu_command} !== {1'b0, 2'b00, m_a, m_b, m_c})
            $display("FAIL idle_hold: cycle %0d busy=%b rdy=%b A=%h B=%h cmd=%h expected A=%h B=%h cmd=%h",
                     i, busy, req_ready, alu_operandA, alu_operandB, alu_command, m_a, m_b, m_c);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [31:0] a0, b0, a1, b1;
      for (int i = 0; i < 20; i++) begin
         a0 = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
         b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
         a1 = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
         b1 = ($urandom_range(0, 3) == 0) ? 32'h00000001 : $urandom;
         op_cycle(2'($urandom_range(1, 3)), a0, b0, 3'($urandom_range(0, 7)),
                  a1, b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      req_valid = 2'b00;
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_flags();
      test_backpressure();
      test_reset_mid_exec();
      test_random();
      test_idle_hold();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
